// File: rtl/wb_dual_port_arbiter.sv
// wb_dual_port_arbiter
//   Shares one classic Wishbone master port between an instruction-fetch
//   requester (port I, read-only) and a load/store requester (port D).
//   Round-robin arbitration, request latching at grant, one-cycle response
//   pulses and a bus-timeout error response. All outputs are registered.
//
// Ports
//   sys_clk, rst_n          clock, async active-low reset
//   i_req_i/i_addr_i        port I request (held until i_ack_o)
//   i_ack_o/i_err_o/i_rdata_o  port I response (err/rdata valid with ack)
//   d_req_i/d_we_i/d_sel_i/d_addr_i/d_wdata_i  port D request
//   d_ack_o/d_err_o/d_rdata_o  port D response
//   core_*                  Wishbone master towards the controller
module wb_dual_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    i_req_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic                    i_ack_o,
  output logic                    i_err_o,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_sel_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_ack_o,
  output logic                    d_err_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    core_cyc,
  output logic                    core_stb,
  output logic                    core_we,
  output logic [DATA_WIDTH/8-1:0] core_sel,
  output logic [ADDR_WIDTH-1:0]   core_addr,
  output logic [DATA_WIDTH-1:0]   core_data_out,
  input  logic [DATA_WIDTH-1:0]   core_data_in,
  input  logic                    core_ack
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW:0] TO_LIM = (CW+1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [SW-1:0]         sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t        state, state_nxt;
  req_t          req_q;
  logic          owner_d;   // 1: current transaction belongs to port D
  logic          last_d;    // 1: last grant went to port D
  logic          gnt_i, gnt_d, timed_out;
  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_inc;

  assign core_we       = req_q.we;
  assign core_sel      = req_q.sel;
  assign core_addr     = req_q.addr;
  assign core_data_out = req_q.wdata;

  always_comb begin
    state_nxt = state;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    timed_out = 1'b0;
    cnt_inc   = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    case (state)
      S_IDLE: begin
        // On contention the port that did not win last time goes next.
        if (i_req_i && (!d_req_i || last_d)) gnt_i = 1'b1;
        else if (d_req_i)                    gnt_d = 1'b1;
        if (gnt_i || gnt_d) state_nxt = S_BUS;
      end
      S_BUS: begin
        // A real ack wins over a timeout landing in the same cycle.
        if (core_ack) state_nxt = S_RESP;
        else if (TO_EN && cnt_inc == TO_LIM) begin
          timed_out = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_q     <= '0;
      owner_d   <= 1'b0;
      last_d    <= 1'b1;
      cnt       <= '0;
      core_cyc  <= 1'b0;
      core_stb  <= 1'b0;
      i_ack_o   <= 1'b0;
      i_err_o   <= 1'b0;
      i_rdata_o <= '0;
      d_ack_o   <= 1'b0;
      d_err_o   <= 1'b0;
      d_rdata_o <= '0;
    end else begin
      state   <= state_nxt;
      i_ack_o <= 1'b0;
      d_ack_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_i || gnt_d) begin
            core_cyc <= 1'b1;
            core_stb <= 1'b1;
            owner_d  <= gnt_d;
            last_d   <= gnt_d;
            cnt      <= '0;
            if (gnt_d) req_q <= '{we: d_we_i, sel: d_sel_i, addr: d_addr_i, wdata: d_wdata_i};
            else       req_q <= '{we: 1'b0, sel: {SW{1'b1}}, addr: i_addr_i, wdata: '0};
          end
        end
        S_BUS: begin
          if (state_nxt == S_RESP) begin
            core_cyc <= 1'b0;
            core_stb <= 1'b0;
            if (owner_d) begin
              d_ack_o   <= 1'b1;
              d_err_o   <= timed_out;
              d_rdata_o <= timed_out ? '0 : core_data_in;
            end else begin
              i_ack_o   <= 1'b1;
              i_err_o   <= timed_out;
              i_rdata_o <= timed_out ? '0 : core_data_in;
            end
          end else begin
            cnt <= cnt_inc[CW-1:0];
          end
        end
        S_RESP:  cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dual_port_arbiter.sv
module tb_wb_dual_port_arbiter;
  localparam int AW = 32, DW = 32, SW = 4, TO = 8;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic          i_req_i;
  logic [AW-1:0] i_addr_i;
  logic          i_ack_o, i_err_o;
  logic [DW-1:0] i_rdata_o;
  logic          d_req_i, d_we_i;
  logic [SW-1:0] d_sel_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_ack_o, d_err_o;
  logic [DW-1:0] d_rdata_o;
  logic          core_cyc, core_stb, core_we;
  logic [SW-1:0] core_sel;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_data_out, core_data_in;
  logic          core_ack;

  always #5 sys_clk = ~sys_clk;

  wb_dual_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i),
    .i_ack_o(i_ack_o), .i_err_o(i_err_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_rdata_o(d_rdata_o),
    .core_cyc(core_cyc), .core_stb(core_stb), .core_we(core_we), .core_sel(core_sel),
    .core_addr(core_addr), .core_data_out(core_data_out),
    .core_data_in(core_data_in), .core_ack(core_ack)
  );

  typedef struct {
    bit            port;   // 1 = D
    logic [AW-1:0] addr;
    logic          we;
    logic [SW-1:0] sel;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sb();
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty observed=0 expected=nonzero");
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_i(input logic [AW-1:0] addr, input logic [DW-1:0] rdata);
    exp_t e;
    e = '{port: 1'b0, addr: addr, we: 1'b0, sel: 4'hF, wdata: '0, rdata: rdata, err: 1'b0};
    sb.push_back(e);
  endtask

  task automatic push_d(input logic [AW-1:0] addr, input logic we, input logic [SW-1:0] sel,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input logic err);
    exp_t e;
    e = '{port: 1'b1, addr: addr, we: we, sel: sel, wdata: wdata, rdata: rdata, err: err};
    sb.push_back(e);
  endtask

  // Pops the oldest expected response and compares against the RESP cycle.
  task automatic chk_resp();
    exp_t e;
    chk_sb();
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("ack_i", i_ack_o, !e.port);
    chk("ack_d", d_ack_o, e.port);
    chk("resp_cyc", core_cyc, 1'b0);
    if (e.port) begin
      chk("d_rdata", d_rdata_o, e.rdata);
      chk("d_err", d_err_o, e.err);
    end else begin
      chk("i_rdata", i_rdata_o, e.rdata);
      chk("i_err", i_err_o, e.err);
    end
  endtask

  // Slave: waits for cyc, holds BUS for ncyc cycles checking the latched
  // request, acks on the last one unless never, then checks the response.
  task automatic serve(input int ncyc, input bit never, input bit scramble, output int lat);
    exp_t e;
    int n = 0;
    while (!core_cyc && n < 20) begin tick(); n++; end
    lat = n;
    chk("cyc_start", core_cyc, 1'b1);
    chk_sb();
    if (sb.size() == 0) return;
    e = sb[0];
    for (int i = 0; i < ncyc; i++) begin
      chk("bus_cyc", core_cyc, 1'b1);
      chk("bus_stb", core_stb, 1'b1);
      chk("bus_addr", core_addr, e.addr);
      chk("bus_we", core_we, e.we);
      chk("bus_sel", core_sel, e.sel);
      chk("bus_wdata", core_data_out, e.wdata);
      chk("bus_noack", {i_ack_o, d_ack_o}, 2'b00);
      if (scramble && i == 0) begin
        d_addr_i = ~d_addr_i; d_wdata_i = ~d_wdata_i; d_sel_i = ~d_sel_i; d_we_i = ~d_we_i;
      end
      if (i == ncyc - 1 && !never) begin
        core_ack = 1'b1;
        core_data_in = e.rdata;
      end
      tick();
    end
    core_ack = 1'b0;
    core_data_in = 32'hBAD0BAD0;
    chk_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; i_req_i = 1'b0; i_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_sel_i = '0; d_addr_i = '0; d_wdata_i = '0;
    core_ack = 1'b0; core_data_in = 32'hBAD0BAD0;
    tick(); tick();
    chk("rst_cyc", core_cyc, 1'b0);
    chk("rst_stb", core_stb, 1'b0);
    chk("rst_we", core_we, 1'b0);
    chk("rst_sel", core_sel, 4'h0);
    chk("rst_addr", core_addr, 32'h0);
    chk("rst_acks", {i_ack_o, d_ack_o, i_err_o, d_err_o}, 4'h0);
    chk("rst_rdata", {i_rdata_o, d_rdata_o}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Single I fetch, zero-wait slave
    i_req_i = 1'b1; i_addr_i = 32'h100;
    push_i(32'h100, 32'h00000013);
    serve(1, 1'b0, 1'b0, lat);
    chk("lat_first", lat, 1);
    i_req_i = 1'b0;
    tick();
    chk("post_noack", {i_ack_o, d_ack_o}, 2'b00);

    // Stray ack in IDLE is ignored
    core_ack = 1'b1; core_data_in = 32'hFFFF0000;
    tick();
    core_ack = 1'b0;
    chk("stray_cyc", core_cyc, 1'b0);
    tick();
    chk("stray_noack", {i_ack_o, d_ack_o}, 2'b00);
    chk("stray_rdata", i_rdata_o, 32'h00000013);

    // Fairness: fresh reset, both held, expect I D I D
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    i_req_i = 1'b1; i_addr_i = 32'h400;
    d_req_i = 1'b1; d_addr_i = 32'h800; d_we_i = 1'b0; d_sel_i = 4'hF; d_wdata_i = 32'h11112222;
    push_i(32'h400, 32'hA1A1A1A1);
    push_d(32'h800, 1'b0, 4'hF, 32'h11112222, 32'hB2B2B2B2, 1'b0);
    push_i(32'h400, 32'hA3A3A3A3);
    push_d(32'h800, 1'b0, 4'hF, 32'h11112222, 32'hB4B4B4B4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      serve(1, 1'b0, 1'b0, lat);
      chk("lat_rr", lat, (k == 0) ? 1 : 2);
    end
    i_req_i = 1'b0; d_req_i = 1'b0;
    tick();
    chk("hold_i_rdata", i_rdata_o, 32'hA3A3A3A3);

    // D write with a 5-cycle wait
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h2000; d_wdata_i = 32'hCAFEF00D; d_sel_i = 4'b0011;
    push_d(32'h2000, 1'b1, 4'b0011, 32'hCAFEF00D, 32'h77777777, 1'b0);
    serve(6, 1'b0, 1'b0, lat);
    d_req_i = 1'b0;
    tick();

    // Timeout after 8 BUS cycles, then a normal request
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h3000; d_wdata_i = '0; d_sel_i = 4'hF;
    push_d(32'h3000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
    serve(TO, 1'b1, 1'b0, lat);
    d_addr_i = 32'h3004;
    push_d(32'h3004, 1'b0, 4'hF, 32'h0, 32'h00005A5A, 1'b0);
    serve(1, 1'b0, 1'b0, lat);
    d_req_i = 1'b0;
    tick();

    // Requester inputs change during BUS
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h4000; d_wdata_i = 32'h12345678; d_sel_i = 4'hF;
    push_d(32'h4000, 1'b0, 4'hF, 32'h12345678, 32'h600D600D, 1'b0);
    serve(3, 1'b0, 1'b1, lat);
    d_req_i = 1'b0; d_we_i = 1'b0; d_sel_i = 4'hF;
    tick();

    // Reset pulse mid-BUS
    i_req_i = 1'b1; i_addr_i = 32'h500;
    tick();
    chk("mid_bus_cyc", core_cyc, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_cyc", core_cyc, 1'b0);
    chk("async_stb", core_stb, 1'b0);
    @(posedge sys_clk); #1;
    chk("rst_noack", {i_ack_o, d_ack_o}, 2'b00);
    rst_n = 1'b1;
    d_req_i = 1'b1; d_addr_i = 32'h600; d_we_i = 1'b0; d_sel_i = 4'hF; d_wdata_i = '0;
    push_i(32'h500, 32'h11111111);
    push_d(32'h600, 1'b0, 4'hF, 32'h0, 32'h22222222, 1'b0);
    serve(1, 1'b0, 1'b0, lat);
    chk("lat_after_rst", lat, 1);
    i_req_i = 1'b0;
    serve(1, 1'b0, 1'b0, lat);
    d_req_i = 1'b0;
    tick();
    chk("end_noack", {i_ack_o, d_ack_o}, 2'b00);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
